// File: rtl/dispatcher.sv
// Round-robin dispatcher: spreads one valid/ready stream over REQ_WIDTH lanes.
// Each lane has a one-entry output register, so one beat can be accepted per cycle.
module dispatcher #(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DW-1:0]           data_in,
  output logic                    ready_out,
  input  logic [REQ_WIDTH-1:0]    ready_in,
  output logic [REQ_WIDTH-1:0]    valid_out,
  output logic [REQ_WIDTH*DW-1:0] data_out,
  output logic                    busy
);

  localparam logic [REQ_WIDTH-1:0] LSB_ONE = REQ_WIDTH'(1);

  logic [REQ_WIDTH-1:0]    valid_r;
  logic [REQ_WIDTH-1:0]    mask_r;
  logic [REQ_WIDTH*DW-1:0] data_r;
  logic [REQ_WIDTH-1:0]    free_s;
  logic [REQ_WIDTH-1:0]    masked_s;
  logic [REQ_WIDTH-1:0]    grant_s;
  logic [REQ_WIDTH-1:0]    mask_next_s;
  logic                    accept_s;

  // Isolates the lowest set bit of a vector (two's-complement trick).
  function automatic logic [REQ_WIDTH-1:0] lowest_one(input logic [REQ_WIDTH-1:0] vec);
    return vec & (~vec + LSB_ONE);
  endfunction

  // Lane availability, rotating-priority grant and the mask that follows it.
  always_comb begin
    free_s   = ~valid_r | ready_in;
    masked_s = free_s & mask_r;
    if (|masked_s) begin
      grant_s = lowest_one(masked_s);
    end else begin
      grant_s = lowest_one(free_s);
    end
    // Bits strictly above the granted lane; all-zero when the top lane wins.
    mask_next_s = ~(grant_s | (grant_s - LSB_ONE));
    accept_s    = valid_in & (|free_s);
  end

  assign ready_out = |free_s;
  assign valid_out = valid_r;
  assign data_out  = data_r;
  assign busy      = |valid_r;

  // Priority mask register: advances only when a beat is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r <= '1;
    end else if (accept_s) begin
      mask_r <= mask_next_s;
    end else begin
      mask_r <= mask_r;
    end
  end

  // Per-lane output registers: load on grant, otherwise drain or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      data_r  <= '0;
    end else begin
      for (int j = 0; j < REQ_WIDTH; j++) begin
        if (accept_s && grant_s[j]) begin
          valid_r[j]          <= 1'b1;
          data_r[j*DW +: DW]  <= data_in;
        end else if (ready_in[j]) begin
          valid_r[j]          <= 1'b0;
        end else begin
          valid_r[j]          <= valid_r[j];
        end
      end
    end
  end

endmodule

// File: doc/dispatcher.md
# dispatcher

Single-stream to N-lane round-robin dispatcher: the transmit-side counterpart of the N-to-1 round-robin arbiter. It accepts one valid/ready/data stream and hands each accepted beat to exactly one of REQ_WIDTH downstream consumers. Lanes are picked in rotating priority among the lanes that can take a beat. Each lane has a one-entry output register, so outputs are fully registered and throughput is one beat per cycle.

## Interface
- REQ_WIDTH, 4, number of downstream lanes (>=1)
- DW, 8, data width per beat in bits
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- valid_in  input  1  upstream beat valid
- data_in  input  DW  upstream beat payload
- ready_out  output  1  upstream ready (combinational)
- ready_in  input  REQ_WIDTH  per-lane consumer ready
- valid_out  output  REQ_WIDTH  per-lane beat valid (registered)
- data_out  output  REQ_WIDTH*DW  per-lane payload; lane i at [i*DW +: DW] (registered)
- busy  output  1  OR of valid_out

## Operation
- Lane i is free when ~valid_out[i] | ready_in[i]. A full lane that is draining this cycle counts as free.
- ready_out = |free. It depends on ready_in and valid_out only, never on valid_in.
- Accept occurs when valid_in & ready_out.
- Lane selection uses a priority mask `mask`, reset to all ones:
  - masked = free & mask.
  - If masked != 0, grant the lowest-index set bit of masked.
  - Otherwise grant the lowest-index set bit of free.
  - grant is one-hot or zero.
- On accept with grant lane g:
  - data_out[g] <= data_in.
  - valid_out[g] <= 1.
  - mask <= bits strictly above g set, all others clear. If g = REQ_WIDTH-1, the mask becomes 0, so the next pick falls back to the unmasked lowest free lane, which wraps to lane 0.
- With no accept, mask holds.
- For each lane j not loaded this cycle: if valid_out[j] & ready_in[j], then valid_out[j] <= 0. data_out[j] holds its value; it is not cleared.
- Lane hold rule: while valid_out[j] & ~ready_in[j], data_out[j] and valid_out[j] must not change.
- Exactly one lane is loaded per accept. No beat is duplicated or dropped. The order of beats across lanes follows the grant sequence.

## Timing
- Reset (rst=0, asynchronous):
  - valid_out = 0, data_out = 0, mask = all ones, busy = 0.
  - ready_out is therefore 1 immediately after reset.
  - Beats held in lanes are discarded on reset mid-operation.
- Release of reset is synchronized externally; the block only requires rst to deassert away from the clk edge.
- Latency: a beat accepted at edge k appears on valid_out[g] and data_out[g] right after edge k. It is visible during cycle k+1.
- Throughput: one accept per cycle whenever any lane is free.
- Simultaneous drain and load on the same lane (valid_out[g] & ready_in[g] & accept to g): the lane stays valid and carries the new data, with no bubble.
- All lanes full, none ready: ready_out = 0. mask and lane state are unchanged even if valid_in = 1.
- REQ_WIDTH = 1: the mask is always 0 after the first accept, and the grant is always lane 0. The block degenerates to a single pipeline register.
- valid_in may drop without acceptance. Upstream data_in is sampled only at accept.

## Test plan
- Reset, then 8 back-to-back beats 0x10..0x17 with ready_in=4'b1111:
  - lanes load in order 0,1,2,3,0,1,2,3.
  - ready_out stays 1 throughout.
  - each value appears 1 cycle after its accept.
- Backpressure with ready_in=4'b0000 and 5 beats offered:
  - 4 beats accepted into lanes 0..3.
  - ready_out=0 on the 5th and held.
  - data_out stable.
  - asserting ready_in[2] alone loads the 5th beat into lane 2 in the same cycle lane 2 drains.
- Skip behaviour:
  - setup: lanes 0 and 1 full and stalled, last grant lane 1, ready_in=4'b0000.
  - one beat goes to lane 2, the next to lane 3.
  - a third beat is refused until a lane drains.
  - with ready_in[0] then high, the beat goes to lane 0 (wrap-around).
- Mask wrap: grant lane 3 while all lanes are free; the next beat must go to lane 0.
- Asynchronous reset asserted mid-burst between clock edges, with lanes 1 and 3 holding data:
  - valid_out=0 and data_out=0 immediately, before the next edge.
  - after release, the first beat goes to lane 0.
- Scoreboard random test, 10k cycles, random valid_in/ready_in:
  - every accepted beat exits exactly once.
  - hold rule never violated.
  - ready_out == |free every cycle.
